// File: rtl/taxi_episode_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : taxi_episode_ctrl
// Brief   : Taxi episode driver. Seeds episodes from a 16-bit LFSR, steps the
//           combinational core and returns observations over valid/ready.
//           Optional macro TAXI_FIXED_SEED_EN reloads the LFSR on each start.
// Revision: 1.0 - initial release
// ============================================================================
module taxi_episode_ctrl #(
  parameter int          MAX_STEPS = 200,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          RET_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             act_valid,
  output logic             act_ready,
  input  logic [2:0]       act_data,
  output logic             obs_valid,
  input  logic             obs_ready,
  output logic [8:0]       obs_state,
  output logic [1:0]       obs_reward,
  output logic             obs_terminated,
  output logic             obs_truncated,
  output logic [2:0]       env_action,
  output logic [8:0]       env_state,
  input  logic [8:0]       env_next_state,
  input  logic [1:0]       env_reward,
  input  logic             env_terminated,
  output logic [9:0]       step_count,
  output logic [RET_W-1:0] ep_return,
  output logic             illegal_act
);

  localparam logic [2:0] c_ST_IDLE     = 3'd0;
  localparam logic [2:0] c_ST_SEED     = 3'd1;
  localparam logic [2:0] c_ST_OBS      = 3'd2;
  localparam logic [2:0] c_ST_WAIT_ACT = 3'd3;
  localparam logic [2:0] c_ST_STEP     = 3'd4;
  localparam logic [2:0] c_ST_DONE     = 3'd5;

  localparam logic [9:0]       c_MAX_STEPS = 10'(MAX_STEPS);
  localparam logic [RET_W-1:0] c_RET_MAX   = {1'b0, {(RET_W-1){1'b1}}};
  localparam logic [RET_W-1:0] c_RET_MIN   = {1'b1, {(RET_W-1){1'b0}}};

  logic [2:0]       r_fsm;
  logic [2:0]       w_fsm_next;
  logic [15:0]      r_lfsr;
  logic [15:0]      w_lfsr_next;
  logic [8:0]       r_state;
  logic [1:0]       r_reward;
  logic             r_term;
  logic             r_trunc;
  logic [2:0]       r_action;
  logic [9:0]       r_step;
  logic [RET_W-1:0] r_ret;
  logic             r_illegal;

  logic [2:0]       w_row;
  logic [2:0]       w_col;
  logic [1:0]       w_pass;
  logic [1:0]       w_dest;
  logic             w_cand_ok;
  logic [8:0]       w_cand;
  logic             w_act_illegal;
  logic [9:0]       w_step_inc;
  logic [5:0]       w_inc;
  logic [RET_W:0]   w_sum;
  logic [RET_W-1:0] w_ret_next;

  assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

  assign w_row     = r_lfsr[2:0];
  assign w_col     = r_lfsr[5:3];
  assign w_pass    = r_lfsr[7:6];
  assign w_dest    = r_lfsr[9:8];
  assign w_cand_ok = (w_row <= 3'd4) && (w_col <= 3'd4) && (w_pass != w_dest);
  assign w_cand    = ({6'd0, w_row} * 9'd100) + ({6'd0, w_col} * 9'd20)
                   + {5'd0, w_pass, 2'b00} + {7'd0, w_dest};

  assign w_act_illegal = (act_data[2:1] == 2'b11);
  assign w_step_inc    = r_step + 10'd1;

  always_comb begin
    w_inc = 6'd0;
    case (env_reward)
      2'b00:   w_inc = 6'b111111;  // -1
      2'b01:   w_inc = 6'd20;
      2'b10:   w_inc = 6'b110110;  // -10
      default: w_inc = 6'd0;
    endcase
  end

  // One guard bit catches overflow; clamp to the signed rails.
  assign w_sum = {r_ret[RET_W-1], r_ret} + {{(RET_W-5){w_inc[5]}}, w_inc};

  always_comb begin
    w_ret_next = w_sum[RET_W-1:0];
    if (w_sum[RET_W] != w_sum[RET_W-1]) begin
      w_ret_next = w_sum[RET_W] ? c_RET_MIN : c_RET_MAX;
    end
  end

`ifdef TAXI_FIXED_SEED_EN
  logic w_start_acc;
  assign w_start_acc = start && ((r_fsm == c_ST_IDLE) || (r_fsm == c_ST_DONE));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_start_acc) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= w_lfsr_next;
    end
  end
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= w_lfsr_next;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fsm <= c_ST_IDLE;
    end else begin
      r_fsm <= w_fsm_next;
    end
  end

  always_comb begin
    w_fsm_next = r_fsm;
    case (r_fsm)
      c_ST_IDLE:     if (start) w_fsm_next = c_ST_SEED;
      c_ST_SEED:     if (w_cand_ok) w_fsm_next = c_ST_OBS;
      c_ST_OBS: begin
        if (obs_ready) w_fsm_next = (r_term || r_trunc) ? c_ST_DONE : c_ST_WAIT_ACT;
      end
      c_ST_WAIT_ACT: begin
        if (act_valid) w_fsm_next = w_act_illegal ? c_ST_OBS : c_ST_STEP;
      end
      c_ST_STEP:     w_fsm_next = c_ST_OBS;
      c_ST_DONE:     if (start) w_fsm_next = c_ST_SEED;
      default:       w_fsm_next = c_ST_IDLE;
    endcase
  end

  always_comb begin
    obs_valid = (r_fsm == c_ST_OBS);
    act_ready = (r_fsm == c_ST_WAIT_ACT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= 9'd0;
      r_reward  <= 2'b11;
      r_term    <= 1'b0;
      r_trunc   <= 1'b0;
      r_action  <= 3'd0;
      r_step    <= 10'd0;
      r_ret     <= '0;
      r_illegal <= 1'b0;
    end else begin
      case (r_fsm)
        c_ST_SEED: begin
          if (w_cand_ok) begin
            r_state  <= w_cand;
            r_reward <= 2'b11;
            r_term   <= 1'b0;
            r_trunc  <= 1'b0;
            r_step   <= 10'd0;
            r_ret    <= '0;
          end
        end
        c_ST_WAIT_ACT: begin
          if (act_valid) begin
            r_action <= act_data;
            if (w_act_illegal) begin
              r_illegal <= 1'b1;
              r_reward  <= 2'b00;
            end
          end
        end
        c_ST_STEP: begin
          r_state  <= env_next_state;
          r_reward <= env_reward;
          r_term   <= env_terminated;
          r_step   <= w_step_inc;
          r_ret    <= w_ret_next;
          r_trunc  <= (w_step_inc == c_MAX_STEPS) && !env_terminated;
        end
        default: ;
      endcase
    end
  end

  assign obs_state      = r_state;
  assign obs_reward     = r_reward;
  assign obs_terminated = r_term;
  assign obs_truncated  = r_trunc;
  assign env_action     = r_action;
  assign env_state      = r_state;
  assign step_count     = r_step;
  assign ep_return      = r_ret;
  assign illegal_act    = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_taxi_episode_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_taxi_episode_ctrl
// Brief   : Directed, table-driven bench for taxi_episode_ctrl with a stub
//           step core and a reference LFSR for the seeding sequence.
// Revision: 1.0 - initial release
// ============================================================================
module tb_taxi_episode_ctrl;

  localparam int          TB_MAX  = 8;
  localparam int          TB_RW   = 7;
  localparam logic [15:0] TB_SEED = 16'hACE1;
  localparam int          NV      = 22;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             act_valid;
  logic             act_ready;
  logic [2:0]       act_data;
  logic             obs_valid;
  logic             obs_ready;
  logic [8:0]       obs_state;
  logic [1:0]       obs_reward;
  logic             obs_terminated;
  logic             obs_truncated;
  logic [2:0]       env_action;
  logic [8:0]       env_state;
  logic [8:0]       env_next_state;
  logic [1:0]       env_reward;
  logic             env_terminated;
  logic [9:0]       step_count;
  logic [TB_RW-1:0] ep_return;
  logic             illegal_act;

  taxi_episode_ctrl #(
    .MAX_STEPS (TB_MAX),
    .LFSR_SEED (TB_SEED),
    .RET_W     (TB_RW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .act_valid      (act_valid),
    .act_ready      (act_ready),
    .act_data       (act_data),
    .obs_valid      (obs_valid),
    .obs_ready      (obs_ready),
    .obs_state      (obs_state),
    .obs_reward     (obs_reward),
    .obs_terminated (obs_terminated),
    .obs_truncated  (obs_truncated),
    .env_action     (env_action),
    .env_state      (env_state),
    .env_next_state (env_next_state),
    .env_reward     (env_reward),
    .env_terminated (env_terminated),
    .step_count     (step_count),
    .ep_return      (ep_return),
    .illegal_act    (illegal_act)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       first;
    logic [2:0] act;
    logic [8:0] nxt;
    logic [1:0] rew;
    logic       term;
    logic       hold;
    logic [1:0] e_rew;
    int         e_step;
    int         e_ret;
    logic       e_term;
    logic       e_trunc;
  } vec_t;

  vec_t vt [NV];

  function automatic vec_t mk(input logic f, input logic [2:0] a, input int nxt,
                              input logic [1:0] rw, input logic tm, input logic hd,
                              input logic [1:0] erw, input int es, input int er,
                              input logic et, input logic etr);
    vec_t v;
    v.first = f;  v.act = a;  v.nxt = 9'(nxt);  v.rew = rw;  v.term = tm;
    v.hold = hd;  v.e_rew = erw;  v.e_step = es;  v.e_ret = er;
    v.e_term = et;  v.e_trunc = etr;
    return v;
  endfunction

  function automatic logic [15:0] lfsr_nx(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic cand_ok(input logic [15:0] l);
    return (l[2:0] <= 3'd4) && (l[5:3] <= 3'd4) && (l[7:6] != l[9:8]);
  endfunction

  function automatic int cand_enc(input logic [15:0] l);
    return int'(l[2:0]) * 100 + int'(l[5:3]) * 20 + int'(l[7:6]) * 4 + int'(l[9:8]);
  endfunction

  // Reference LFSR tracking the spec'd sequence from reset.
  logic [15:0] m_lfsr;
  logic        start_ok = 1'b0;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_lfsr <= TB_SEED;
    end else begin
`ifdef TAXI_FIXED_SEED_EN
      if (start && start_ok) m_lfsr <= TB_SEED;
      else                   m_lfsr <= lfsr_nx(m_lfsr);
`else
      m_lfsr <= lfsr_nx(m_lfsr);
`endif
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_reward"}, 64'(obs_reward), 64'd3);
    chk({nm, "_outs"}, 64'({obs_valid, act_ready, obs_state, obs_terminated, obs_truncated,
                            env_action, env_state, step_count, ep_return, illegal_act}), 64'd0);
  endtask

  int   exp_state;
  logic exp_ill = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_obs();
    obs_ready = 1'b1;
    tick();
    obs_ready = 1'b0;
  endtask

  task automatic start_ep();
    logic [15:0] l;
    int k;
    int lat;
    int st;
    start_ok = 1'b1;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    start_ok = 1'b0;
    l = m_lfsr;
    k = 0;
    while (!cand_ok(l) && k < 200) begin
      l = lfsr_nx(l);
      k++;
    end
    exp_state = cand_enc(l);
    lat = 0;
    while (!obs_valid && lat < 300) begin
      tick();
      lat++;
    end
    chk_i("seed_latency", lat, k + 1);
    chk("seed_state", 64'(obs_state), 64'(exp_state));
    st = int'(obs_state);
    chk("seed_row_le4", 64'(st / 100 <= 4), 64'd1);
    chk("seed_col_le4", 64'((st % 100) / 20 <= 4), 64'd1);
    chk("seed_pass_ne_dest", 64'(((st % 20) / 4) != (st % 4)), 64'd1);
    chk("seed_reward", 64'(obs_reward), 64'd3);
    chk("seed_step", 64'(step_count), 64'd0);
    chk_i("seed_ret", int'($signed(ep_return)), 0);
    chk("seed_flags", 64'({obs_terminated, obs_truncated}), 64'd0);
    accept_obs();
  endtask

  task automatic send_act(input vec_t v);
    int   lat;
    int   prev;
    logic illegal;
    chk("act_ready", 64'(act_ready), 64'd1);
    illegal        = (v.act >= 3'd6);
    prev           = exp_state;
    act_valid      = 1'b1;
    act_data       = v.act;
    env_next_state = v.nxt;
    env_reward     = v.rew;
    env_terminated = v.term;
    tick();
    act_valid = 1'b0;
    lat = 1;
    if (!illegal) begin
      chk("step_env_action", 64'(env_action), 64'(v.act));
      chk("step_env_state", 64'(env_state), 64'(prev));
    end
    while (!obs_valid && lat < 8) begin
      tick();
      lat++;
    end
    chk_i("act_latency", lat, illegal ? 1 : 2);
    exp_state = illegal ? prev : int'(v.nxt);
    exp_ill   = exp_ill | illegal;
  endtask

  task automatic chk_obs(input vec_t v, input string nm);
    chk({nm, "_state"}, 64'(obs_state), 64'(exp_state));
    chk({nm, "_reward"}, 64'(obs_reward), 64'(v.e_rew));
    chk_i({nm, "_step"}, int'(step_count), v.e_step);
    chk_i({nm, "_ret"}, int'($signed(ep_return)), v.e_ret);
    chk({nm, "_term"}, 64'(obs_terminated), 64'(v.e_term));
    chk({nm, "_trunc"}, 64'(obs_truncated), 64'(v.e_trunc));
    chk({nm, "_illegal"}, 64'(illegal_act), 64'(exp_ill));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;  start = 1'b0;  act_valid = 1'b0;  act_data = 3'd0;
    obs_ready = 1'b0;  env_next_state = 9'd0;  env_reward = 2'b00;  env_terminated = 1'b0;

    //             first act nxt rew   tm hd  erw   step ret  term trunc
    vt[0]  = mk(1, 3'd0, 123, 2'b00, 0, 0, 2'b00, 1,  -1,  0, 0);
    vt[1]  = mk(0, 3'd1, 200, 2'b00, 0, 1, 2'b00, 2,  -2,  0, 0);
    vt[2]  = mk(0, 3'd2, 201, 2'b00, 0, 0, 2'b00, 3,  -3,  0, 0);
    vt[3]  = mk(0, 3'd7, 77,  2'b01, 1, 0, 2'b00, 3,  -3,  0, 0);
    vt[4]  = mk(0, 3'd3, 305, 2'b00, 0, 0, 2'b00, 4,  -4,  0, 0);
    vt[5]  = mk(0, 3'd5, 410, 2'b01, 1, 0, 2'b01, 5,  16,  1, 0);
    vt[6]  = mk(1, 3'd4, 21,  2'b01, 0, 0, 2'b01, 1,  20,  0, 0);
    vt[7]  = mk(0, 3'd4, 22,  2'b01, 0, 0, 2'b01, 2,  40,  0, 0);
    vt[8]  = mk(0, 3'd4, 23,  2'b01, 0, 0, 2'b01, 3,  60,  0, 0);
    vt[9]  = mk(0, 3'd4, 24,  2'b01, 0, 0, 2'b01, 4,  63,  0, 0);
    vt[10] = mk(0, 3'd4, 25,  2'b01, 0, 0, 2'b01, 5,  63,  0, 0);
    vt[11] = mk(0, 3'd4, 26,  2'b01, 0, 0, 2'b01, 6,  63,  0, 0);
    vt[12] = mk(0, 3'd4, 27,  2'b01, 0, 0, 2'b01, 7,  63,  0, 0);
    vt[13] = mk(0, 3'd4, 28,  2'b01, 0, 0, 2'b01, 8,  63,  0, 1);
    vt[14] = mk(1, 3'd2, 300, 2'b10, 0, 0, 2'b10, 1, -10,  0, 0);
    vt[15] = mk(0, 3'd2, 301, 2'b10, 0, 0, 2'b10, 2, -20,  0, 0);
    vt[16] = mk(0, 3'd2, 302, 2'b10, 0, 0, 2'b10, 3, -30,  0, 0);
    vt[17] = mk(0, 3'd2, 303, 2'b10, 0, 0, 2'b10, 4, -40,  0, 0);
    vt[18] = mk(0, 3'd2, 304, 2'b10, 0, 0, 2'b10, 5, -50,  0, 0);
    vt[19] = mk(0, 3'd2, 305, 2'b10, 0, 0, 2'b10, 6, -60,  0, 0);
    vt[20] = mk(0, 3'd2, 306, 2'b10, 0, 0, 2'b10, 7, -64,  0, 0);
    vt[21] = mk(0, 3'd1, 307, 2'b01, 1, 0, 2'b01, 8, -44,  1, 0);

    #12;
    chk_reset("reset");
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("idle_obs_valid", 64'(obs_valid), 64'd0);

    for (int i = 0; i < NV; i++) begin
      if (vt[i].first) start_ep();
      send_act(vt[i]);
      chk_obs(vt[i], $sformatf("v%0d", i));
      if (vt[i].hold) begin
        for (int c = 0; c < 5; c++) begin
          start = (c == 1);
          tick();
          start = 1'b0;
          chk("hold_obs_valid", 64'(obs_valid), 64'd1);
          chk("hold_act_ready", 64'(act_ready), 64'd0);
          chk_obs(vt[i], "hold");
        end
      end
      accept_obs();
      if (vt[i].e_term || vt[i].e_trunc) begin
        tick();
        chk("done_valid_ready", 64'({obs_valid, act_ready}), 64'd0);
        chk_i("done_step_held", int'(step_count), vt[i].e_step);
        chk_i("done_ret_held", int'($signed(ep_return)), vt[i].e_ret);
      end
    end

    // Reset asserted while the controller sits in STEP.
    start_ep();
    act_valid = 1'b1;
    act_data  = 3'd0;
    env_next_state = 9'd450;
    env_reward = 2'b00;
    env_terminated = 1'b0;
    tick();
    act_valid = 1'b0;
    chk("step_act_ready", 64'({act_ready, obs_valid}), 64'd0);
    reset = 1'b0;
    #1;
    chk_reset("midstep_reset");
    tick();
    chk_reset("midstep_reset_hold");
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("post_reset_idle", 64'(obs_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/taxi_episode_ctrl.md
Name: taxi_episode_ctrl

Overview:
- Episode driver on the initiator side of the Taxi step core.
- Holds the current 9-bit encoded state and seeds each episode with a random valid start state from an LFSR.
- Accepts actions from the agent, presents each one with the current state to the combinational step core, and registers the returned next state, reward and terminated flag.
- Returns observations to the agent over a valid/ready handshake and tracks the step count, truncation and the accumulated return.

Parameters:
- MAX_STEPS, 200, step count at which the episode is truncated (range 1..1023).
- LFSR_SEED, 16'hACE1, LFSR value after reset; must be non-zero.
- RET_W, 16, width of the signed return accumulator.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins an episode, honoured only in IDLE or DONE.
- act_valid  input  1  agent action valid.
- act_ready  output  1  controller can accept an action.
- act_data  input  3  action 0..5.
- obs_valid  output  1  observation valid.
- obs_ready  input  1  agent accepts the observation.
- obs_state  output  9  encoded state.
- obs_reward  output  2  reward code of the last step: 00 = -1, 01 = +20, 10 = -10, 11 = none (first observation).
- obs_terminated  output  1  episode ended by drop-off.
- obs_truncated  output  1  step count reached MAX_STEPS.
- env_action  output  3  action driven to the step core.
- env_state  output  9  state driven to the step core.
- env_next_state  input  9  step-core next state.
- env_reward  input  2  step-core reward code.
- env_terminated  input  1  step-core terminated flag.
- step_count  output  10  steps taken this episode.
- ep_return  output  RET_W  signed sum of rewards this episode.
- illegal_act  output  1  sticky flag; set when an action of 6 or 7 is received.

Behaviour:
- Reset (reset=0, asynchronous): FSM goes to IDLE, LFSR=LFSR_SEED, and every output is 0 except obs_reward=11.
- LFSR: 16-bit Fibonacci; each cycle shifts left with new bit0 = b15^b13^b12^b10. It advances every cycle out of reset.
- State encoding: state = row*100 + col*20 + pass*4 + dest. row and col are 0..4; pass is 0..3 for a depot or 4 for in taxi; dest is 0..3.
- IDLE: on start, go to SEED.
- SEED: candidate fields are row=lfsr[2:0], col=lfsr[5:3], pass=lfsr[7:6], dest=lfsr[9:8].
  - If row<=4, col<=4 and pass!=dest: register the encoded state, clear step_count, ep_return, obs_terminated and obs_truncated, set obs_reward=11, go to OBS.
  - Otherwise retry on the next cycle with the next LFSR value.
- OBS: obs_valid=1 with outputs stable until obs_ready.
  - If terminated or truncated, go to DONE.
  - Otherwise go to WAIT_ACT.
- WAIT_ACT: act_ready=1; on act_valid, register act_data into env_action.
  - Action 6 or 7: set illegal_act; state, step_count and ep_return are unchanged; go to OBS with obs_reward=00.
  - Action 0..5: go to STEP.
- STEP (one cycle): env_state is the current state; register env_next_state, env_reward and env_terminated.
  - step_count += 1.
  - ep_return += sign-extended reward (-1, +20 or -10); code 11 from the core adds 0.
  - obs_truncated = (step_count+1 == MAX_STEPS) and not env_terminated. Termination has priority when both occur.
  - Go to OBS.
- DONE: obs_valid=0; on start go to SEED. The last values of step_count and ep_return are held until SEED.
- Latency: 2 cycles from the action handshake to obs_valid for a legal action, 1 cycle for an illegal action.
- start is ignored outside IDLE and DONE. A mid-episode restart requires reset.
- ep_return saturates at the signed min/max of RET_W.
- illegal_act is cleared only by reset.

Optional Feature:
- Macro: TAXI_FIXED_SEED_EN.
- Defined: the LFSR is reloaded with LFSR_SEED when start is accepted, so every episode sees the same initial-state sequence (deterministic replay).
- Undefined: the LFSR free-runs across episodes and is loaded only at reset.

Test Plan:
- Reset, then start with the macro defined and a golden LFSR model -> obs_state equals the model's first valid candidate. Check that row<=4, col<=4, pass!=dest, obs_reward=11 and step_count=0.
- Stub core returns env_reward=00 and env_terminated=0 for 3 legal actions -> step_count=3, ep_return=-3, 2-cycle latency per step.
- Stub core returns reward 01 with terminated=1 on step 5 after 4 steps of -1 -> obs_terminated=1, ep_return=16. FSM goes to DONE after obs_ready; the next start restarts with step_count=0.
- MAX_STEPS=4 with the stub never terminating -> 4th observation has obs_truncated=1 and step_count=4. With terminated=1 on that same step, obs_terminated=1 and obs_truncated=0.
- act_data=7 -> illegal_act=1, obs_state unchanged, step_count unchanged, obs_reward=00.
- obs_ready held low for 5 cycles -> obs outputs stable and act_ready=0. Assert reset mid-STEP -> immediate IDLE with all outputs at reset values.
